// File: rtl/pb_pkg.sv
// pb_pkg: shared constants for the pushbutton pulse generator
package pb_pkg;
    localparam int DB_CYCLES_DEFAULT = 4;
    localparam int STAT_L   = 0;
    localparam int STAT_R   = 1;
    localparam int STAT_TIE = 2;
    localparam int STAT_EN  = 3;
endpackage

// File: rtl/pb_debounce.sv
// pb_debounce: 2-flop synchroniser, debounce counter and press-event detect
module pb_debounce #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic evt
);
    logic s1, s2;
    logic [CNT_W-1:0] cnt;
    logic term;
    assign term = cnt == CNT_W'(DB_CYCLES - 1);
    // only a debounced rising level is a press; releases are silent
    assign evt = (s2 != stable) & term & s2;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == stable) cnt <= '0;
            else if (term) begin
                stable <= s2;
                cnt    <= '0;
            end else cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/pb_pulse_gen.sv
// pb_pulse_gen: debounced, arbitrated single-cycle step pulses from two pushbuttons
module pb_pulse_gen
    import pb_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pbl_raw,
    input  logic       pbr_raw,
    input  logic       en,
    output logic       pbl,
    output logic       pbr,
    output logic       tie,
    output logic [3:0] status
);
    logic stable_l, stable_r, evt_l, evt_r, tie_sticky;
    pb_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_l (
        .clk(clk), .rst(rst), .raw(pbl_raw), .stable(stable_l), .evt(evt_l)
    );
    pb_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_r (
        .clk(clk), .rst(rst), .raw(pbr_raw), .stable(stable_r), .evt(evt_r)
    );
    // simultaneous presses cancel into a tie instead of a step
    always_ff @(posedge clk) begin
        if (rst) begin
            pbl        <= 1'b0;
            pbr        <= 1'b0;
            tie        <= 1'b0;
            tie_sticky <= 1'b0;
        end else begin
            pbl        <= en & evt_l & ~evt_r;
            pbr        <= en & evt_r & ~evt_l;
            tie        <= en & evt_l & evt_r;
            tie_sticky <= tie_sticky | (en & evt_l & evt_r);
        end
    end
    always_comb begin
        status           = '1;
        status[STAT_L]   = ~stable_l;
        status[STAT_R]   = ~stable_r;
        status[STAT_TIE] = ~tie_sticky;
        status[STAT_EN]  = en;
    end
endmodule

// File: doc/pb_pulse_gen.md
Name: pb_pulse_gen

Overview:
Pushbutton front end for the tug-of-war datapath. Each raw push-button is synchronised, debounced and edge-detected, then the two buttons are arbitrated into single-cycle step pulses. The pulses drive the pbl/pbr step inputs of the position counter, so one physical press produces exactly one step. It is the producing end of the count-up/count-down pulse interface that the position counter consumes.

Parameters:
DB_CYCLES, 4, consecutive stable cycles needed to accept a new button level; legal range is 2 or more.
CNT_W, $clog2(DB_CYCLES), width of each debounce counter.

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  reset; synchronous, active-high.
pbl_raw  in  1  left push-button, asynchronous and bouncy; 1 = pressed.
pbr_raw  in  1  right push-button, asynchronous and bouncy; 1 = pressed.
en  in  1  game-active enable; when low, accepted presses are discarded.
pbl  out  1  one-cycle count-down pulse to the position counter.
pbr  out  1  one-cycle count-up pulse to the position counter.
tie  out  1  one-cycle pulse: both presses were accepted in the same cycle.
status  out  4  active-low debug LEDs.

Behaviour:
- Reset (synchronous, sampled on posedge clk while rst=1):
  - clears both sync flops, debounce counters and stable levels, the tie_sticky flag, and the registered outputs pbl, pbr and tie.
  - After reset, status = 4'b1111 when en=1 (4'b0111 when en=0).
- Synchroniser, per button: 2-flop chain, raw -> s1 -> s2.
- Debounce, per button, with state {stable, cnt}:
  - If s2 == stable: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: stable <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any bounce back to the stable level before the terminal count restarts the count at 0.
- Press event (combinational): evt = (s2 != stable) & (cnt == DB_CYCLES-1) & s2. Only the 0->1 transition is an event; a debounced release never produces an event.
- Output registers, updated each clock:
  - pbl <= en & evt_l & ~evt_r
  - pbr <= en & evt_r & ~evt_l
  - tie <= en & evt_l & evt_r
  - tie_sticky <= tie_sticky | (en & evt_l & evt_r)
- Latency: raw is sampled high at edge 0 and held. The pulse is high for exactly the one cycle following edge DB_CYCLES+1, and never high for more than one cycle per press.
- Simultaneous acceptance: neither step pulse is issued, tie pulses once, and tie_sticky sets. Presses accepted on different cycles are both honoured, even one cycle apart.
- en=0 at the event cycle: the event is dropped with no deferred pulse. Stable still updates, so the button must be released and pressed again.
- Button held through reset: stable=0 after reset, so the held button is accepted as a new press. The pulse appears after edge DB_CYCLES+1 counted from the first non-reset edge.
- status, active-low: [0] = ~stable_l, [1] = ~stable_r, [2] = ~tie_sticky, [3] = en. [3] lights when the game is disabled. tie_sticky is cleared only by rst.

Decomposition:
- Package pb_pkg holds:
  - DB_CYCLES_DEFAULT = 4
  - status bit-index constants STAT_L = 0, STAT_R = 1, STAT_TIE = 2, STAT_EN = 3.
- Sub-module pb_debounce (parameters DB_CYCLES and CNT_W; ports clk, rst, raw, stable, evt) contains the synchroniser, debounce counter and event logic. It is instantiated twice. Arbitration, the output registers and status stay in the top level.

Test Plan:
1. DB_CYCLES=4, en=1, clean pbl_raw high from edge 0, held for 20 cycles -> pbl=1 only in the cycle after edge 5; pbr=0 and tie=0 throughout; status[0]=0 from edge 5.
2. pbl_raw toggling 1,0,1,0 every cycle for 8 cycles, then held high -> no pulse during the bounce; one pbl pulse 5 edges after the final rise is sampled; release with bounce -> no pulse.
3. pbl_raw and pbr_raw rise on the same cycle -> tie=1 for one cycle, pbl=pbr=0, status[2]=0 latched; pbr_raw rising one cycle after pbl_raw -> pbl pulse, then pbr pulse on the next cycle, tie=0.
4. en=0 during an accepted press, then en=1 while still held -> no pulse at any time; release and re-press with en=1 -> one pulse.
5. rst asserted for 2 cycles mid-count (cnt=2) with pbr_raw held -> all outputs 0 after the reset edge; one pbr pulse after edge 5 counted from the first non-reset edge.
6. Press pbr 10 times at 20-cycle spacing -> exactly 10 pbr pulses, each 1 cycle wide; a connected position counter, starting from a known value, moves by exactly +10.
